// File: rtl/wb_arb_pkg.sv
// Shared constants and helpers for the five-source writeback arbiter.
// Select codes follow the writeback 5:1 mux encoding.
package wb_arb_pkg;

  localparam int NSRC  = 5;
  localparam int SEL_W = 3;

  typedef enum logic [SEL_W-1:0] {
    SEL_A = 3'd0,
    SEL_B = 3'd1,
    SEL_C = 3'd2,
    SEL_D = 3'd3,
    SEL_E = 3'd4
  } sel_e;

  function automatic logic [NSRC-1:0] onehot5(
    input logic [SEL_W-1:0] sel
  );
    logic [NSRC-1:0] oh;
    oh = '0;
    case (sel)
      SEL_A:   oh = 5'b00001;
      SEL_B:   oh = 5'b00010;
      SEL_C:   oh = 5'b00100;
      SEL_D:   oh = 5'b01000;
      SEL_E:   oh = 5'b10000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/wb_arb5_rr_pick5.sv
// Rotating-priority encoder: first requester at or after ptr, mod 5.
// An out-of-range ptr behaves as 0.
module rr_pick5
  import wb_arb_pkg::*;
(
  input  logic [NSRC-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] win,
  output logic             any
);

  always_comb begin
    logic [SEL_W-1:0] base;
    logic [3:0]       sum;
    logic [SEL_W-1:0] idx;
    base = (ptr > SEL_E) ? SEL_A : ptr;
    win  = SEL_A;
    any  = 1'b0;
    sum  = '0;
    idx  = '0;
    for (int i = 0; i < NSRC; i++) begin
      sum = {1'b0, base} + 4'(i);
      if (sum >= 4'(NSRC)) begin
        sum = sum - 4'(NSRC);
      end
      idx = sum[SEL_W-1:0];
      if (!any && req[idx]) begin
        any = 1'b1;
        win = idx;
      end
    end
  end

endmodule

// File: rtl/wb_arb5.sv
// Five-source writeback arbiter with a one-entry valid/ready output.
// Define WB_ARB5_FIXED_PRIO_EN for fixed priority (source 0 highest).
module wb_arb5
  import wb_arb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NSRC-1:0]        req_i,
  input  logic [NSRC*DATA_W-1:0] data_i,
  output logic [NSRC-1:0]        gnt_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [DATA_W-1:0]      data_o,
  output logic [SEL_W-1:0]       sel_o
);

  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  win;
  logic              any;
  logic              load;
  logic [DATA_W-1:0] src [NSRC];

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    assign src[k] = data_i[k*DATA_W +: DATA_W];
  end

  rr_pick5 u_pick (
    .req (req_i),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  assign load  = any & (~valid_q | ready_i);
  assign gnt_o = (rst_ni && load) ? onehot5(win) : '0;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    sel_d   = sel_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = src[win];
      sel_d   = win;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= SEL_A;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

`ifdef WB_ARB5_FIXED_PRIO_EN
  assign ptr = SEL_A;
`else
  logic [SEL_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = (win >= SEL_E) ? SEL_A : win + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= SEL_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;
`endif

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign sel_o   = sel_q;

endmodule

// File: tb/tb_wb_arb5.sv
// Directed bench for wb_arb5: driver pushes expected transfers,
// a monitor pops them whenever the output is accepted.
module tb_wb_arb5;

  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic [4:0]    req;
  logic [5*DW-1:0] din;
  logic [4:0]    gnt;
  logic          vld;
  logic          rdy;
  logic [DW-1:0] dout;
  logic [2:0]    sel;

  logic [DW-1:0] d [5];

  typedef struct packed {
    logic [DW-1:0] data;
    logic [2:0]    sel;
  } xfer_t;

  xfer_t sb [$];
  int    tests;
  int    fails;

  assign din = {d[4], d[3], d[2], d[1], d[0]};

  wb_arb5 #(.DATA_W(DW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .req_i   (req),
    .data_i  (din),
    .gnt_o   (gnt),
    .valid_o (vld),
    .ready_i (rdy),
    .data_o  (dout),
    .sel_o   (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm,
                       input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: an accepted output must match the oldest expected transfer.
  always @(negedge clk) begin
    if (rst_n && vld === 1'b1 && rdy === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got sel %0d data %h expected none",
                 sel, dout);
      end else begin
        xfer_t e;
        e = sb.pop_front();
        check("out_data", dout, e.data);
        check("out_sel", {29'd0, sel}, {29'd0, e.sel});
      end
    end
  end

  // One cycle: drive, check grant at negedge, record expected capture.
  task automatic cyc(input logic [4:0] r, input logic rd,
                     input logic [4:0] eg, input string nm);
    xfer_t e;
    req = r;
    rdy = rd;
    @(negedge clk);
    check(nm, {27'd0, gnt}, {27'd0, eg});
    for (int k = 0; k < 5; k++) begin
      if (eg[k]) begin
        e.data = d[k];
        e.sel  = 3'(k);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    rst_n = 1'b0;
    #1;
    check({nm, "_valid"}, {31'd0, vld}, 32'd0);
    check({nm, "_gnt"}, {27'd0, gnt}, 32'd0);
    check({nm, "_sel"}, {29'd0, sel}, 32'd0);
    check({nm, "_data"}, dout, 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    req   = '0;
    rdy   = 1'b0;
    for (int k = 0; k < 5; k++) d[k] = 32'(k + 1);
    repeat (2) @(posedge clk);
    #1;
    check("por_valid", {31'd0, vld}, 32'd0);
    rst_n = 1'b1;

`ifdef WB_ARB5_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) cyc(5'b10010, 1'b1, 5'b00010, "fp_gnt");
    cyc(5'b10000, 1'b1, 5'b10000, "fp_gnt4");
    cyc(5'b00000, 1'b1, 5'b00000, "fp_idle");
`else
    // single source
    d[2] = 32'hDEADBEEF;
    cyc(5'b00100, 1'b1, 5'b00100, "single_gnt");
    cyc(5'b00000, 1'b1, 5'b00000, "single_idle");
    @(negedge clk);
    check("drain_valid", {31'd0, vld}, 32'd0);
    check("drain_hold", dout, 32'hDEADBEEF);
    @(posedge clk);
    #1;

    // pending datum then reset mid-transfer (ptr=3: 3,4,0 -> 0)
    d[0] = 32'h11;
    cyc(5'b00001, 1'b1, 5'b00001, "pend_gnt");
    cyc(5'b00000, 1'b0, 5'b00000, "pend_hold");
    do_reset("rst_mid");

    // round-robin
    for (int k = 0; k < 5; k++) d[k] = 32'(k + 1);
    cyc(5'b11111, 1'b1, 5'b00001, "rr0");
    cyc(5'b11111, 1'b1, 5'b00010, "rr1");
    cyc(5'b11111, 1'b1, 5'b00100, "rr2");
    cyc(5'b11111, 1'b1, 5'b01000, "rr3");
    cyc(5'b11111, 1'b1, 5'b10000, "rr4");
    cyc(5'b11111, 1'b1, 5'b00001, "rr_wrap");

    // backpressure with sel 0 / data 1 held
    for (int i = 0; i < 3; i++) begin
      cyc(5'b00010, 1'b0, 5'b00000, "bp_gnt");
      check("bp_data", dout, 32'h1);
      check("bp_valid", {31'd0, vld}, 32'd1);
    end
    cyc(5'b00010, 1'b1, 5'b00010, "bp_release");

    // wrap: ptr=2 -> grant 4, then 0
    cyc(5'b10000, 1'b1, 5'b10000, "wrap_4");
    cyc(5'b10001, 1'b1, 5'b00001, "wrap_0");
    // ptr=2 after this grant; reset must restart at 0
    cyc(5'b00010, 1'b1, 5'b00010, "pre_rst");
    do_reset("rst_pulse");
    cyc(5'b00110, 1'b1, 5'b00010, "restart");

    // dropped request before grant captures nothing
    cyc(5'b00000, 1'b1, 5'b00000, "drop");
`endif

    repeat (2) cyc(5'b00000, 1'b1, 5'b00000, "idle");
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
